// File: rtl/cnn_layer_accel_job_sequencer_if.sv
// Host/quad handshake bundle for the job sequencer.
// Ports: descriptor, host config words, quad config/job channels, status.
interface cnn_layer_accel_job_sequencer_if #(
  parameter int C_CNT_WIDTH = 16
);
  logic                   desc_valid;
  logic                   desc_ready;
  logic [127:0]           desc_params;
  logic [3:0]             desc_num_cfg;
  logic [1:0]             desc_cfg_sel;
  logic                   cfg_word_valid;
  logic                   cfg_word_ready;
  logic [127:0]           cfg_word_data;
  logic [3:0]             config_valid;
  logic [3:0]             config_accept;
  logic [127:0]           config_data;
  logic                   job_start;
  logic                   job_accept;
  logic [127:0]           job_parameters;
  logic                   job_fetch_request;
  logic                   job_fetch_ack;
  logic                   job_fetch_complete;
  logic                   job_complete;
  logic                   job_complete_ack;
  logic                   busy;
  logic                   done_pulse;
  logic [C_CNT_WIDTH-1:0] jobs_done;
  logic                   timeout_err;
  logic [2:0]             err_state;
  logic                   err_clear;

  // Host + quad side.
  modport master (
    output desc_valid, desc_params, desc_num_cfg, desc_cfg_sel,
    output cfg_word_valid, cfg_word_data, config_accept,
    output job_accept, job_fetch_request, job_fetch_complete,
    output job_complete, err_clear,
    input  desc_ready, cfg_word_ready, config_valid, config_data,
    input  job_start, job_parameters, job_fetch_ack,
    input  job_complete_ack, busy, done_pulse, jobs_done,
    input  timeout_err, err_state
  );

  // Sequencer side.
  modport slave (
    input  desc_valid, desc_params, desc_num_cfg, desc_cfg_sel,
    input  cfg_word_valid, cfg_word_data, config_accept,
    input  job_accept, job_fetch_request, job_fetch_complete,
    input  job_complete, err_clear,
    output desc_ready, cfg_word_ready, config_valid, config_data,
    output job_start, job_parameters, job_fetch_ack,
    output job_complete_ack, busy, done_pulse, jobs_done,
    output timeout_err, err_state
  );
endinterface

// File: rtl/cnn_layer_accel_job_sequencer.sv
// One-job-at-a-time sequencer for the cnn_layer_accel_quad ports.
// Ports: clk_if, rst (sync, active-high), bus (slave modport).
module cnn_layer_accel_job_sequencer #(
  parameter int C_TIMEOUT_CYCLES = 65535,
  parameter int C_CNT_WIDTH      = 16
) (
  input logic                           clk_if,
  input logic                           rst,
  cnn_layer_accel_job_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONFIG = 3'd1,
    S_START  = 3'd2,
    S_FETCH  = 3'd3,
    S_RUN    = 3'd4,
    S_ACK    = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam bit WD_EN = (C_TIMEOUT_CYCLES != 0);
  localparam logic [C_CNT_WIDTH-1:0] WD_LAST =
    C_CNT_WIDTH'(C_TIMEOUT_CYCLES - 1);

  state_t                 state_q;
  logic                   desc_ready_q;
  logic                   job_start_q;
  logic                   fetch_ack_q;
  logic                   cpl_ack_q;
  logic                   done_q;
  logic                   terr_q;
  logic [2:0]             err_state_q;
  logic [127:0]           params_q;
  logic [3:0]             cfg_left_q;
  logic [1:0]             sel_q;
  logic [C_CNT_WIDTH-1:0] jobs_q;
  logic [C_CNT_WIDTH-1:0] wd_q;

  logic in_cfg;
  logic xfer;
  logic leave;
  logic waiting;
  logic timeout;

  assign in_cfg = (state_q == S_CONFIG);
  assign xfer   = in_cfg && bus.cfg_word_valid
                  && bus.config_accept[sel_q];

  // Event that ends the current wait state.
  always_comb begin
    leave = 1'b0;
    unique case (state_q)
      S_CONFIG: leave = xfer && (cfg_left_q == 4'd1);
      S_START:  leave = bus.job_accept;
      S_FETCH:  leave = bus.job_complete
                        || bus.job_fetch_complete;
      S_RUN:    leave = bus.job_complete;
      S_ACK:    leave = !bus.job_complete;
      default:  leave = 1'b0;
    endcase
  end

  assign waiting = (state_q != S_IDLE) && (state_q != S_ERR);
  // A handshake finishing on the last allowed cycle beats the watchdog.
  assign timeout = WD_EN && waiting && (wd_q == WD_LAST) && !leave;

  // Config channel is a pure pass-through while streaming.
  assign bus.config_valid = (in_cfg && bus.cfg_word_valid)
                            ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.config_data    = in_cfg ? bus.cfg_word_data : '0;
  assign bus.cfg_word_ready = in_cfg && bus.config_accept[sel_q];

  assign bus.desc_ready       = desc_ready_q;
  assign bus.job_start        = job_start_q;
  assign bus.job_parameters   = params_q;
  assign bus.job_fetch_ack    = fetch_ack_q;
  assign bus.job_complete_ack = cpl_ack_q;
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.done_pulse       = done_q;
  assign bus.jobs_done        = jobs_q;
  assign bus.timeout_err      = terr_q;
  assign bus.err_state        = err_state_q;

  always_ff @(posedge clk_if) begin
    if (rst) begin
      state_q      <= S_IDLE;
      desc_ready_q <= 1'b0;
      job_start_q  <= 1'b0;
      fetch_ack_q  <= 1'b0;
      cpl_ack_q    <= 1'b0;
      done_q       <= 1'b0;
      terr_q       <= 1'b0;
      err_state_q  <= 3'd0;
      params_q     <= '0;
      cfg_left_q   <= 4'd0;
      sel_q        <= 2'd0;
      jobs_q       <= '0;
      wd_q         <= '0;
    end else begin
      done_q       <= 1'b0;
      fetch_ack_q  <= 1'b0;
      desc_ready_q <= 1'b0;
      wd_q         <= waiting ? wd_q + 1'b1 : '0;
      unique case (state_q)
        S_IDLE: begin
          // Ready only after a full cycle in IDLE.
          desc_ready_q <= 1'b1;
          if (bus.desc_valid && desc_ready_q) begin
            desc_ready_q <= 1'b0;
            params_q     <= bus.desc_params;
            cfg_left_q   <= bus.desc_num_cfg;
            sel_q        <= bus.desc_cfg_sel;
            if (bus.desc_num_cfg != 4'd0) begin
              state_q <= S_CONFIG;
            end else begin
              state_q     <= S_START;
              job_start_q <= 1'b1;
            end
          end
        end
        S_CONFIG: begin
          if (xfer) cfg_left_q <= cfg_left_q - 4'd1;
          if (leave) begin
            state_q     <= S_START;
            job_start_q <= 1'b1;
          end
        end
        S_START: begin
          if (leave) begin
            state_q     <= S_FETCH;
            job_start_q <= 1'b0;
          end
        end
        S_FETCH: begin
          fetch_ack_q <= bus.job_fetch_request;
          if (bus.job_complete) begin
            state_q   <= S_ACK;
            cpl_ack_q <= 1'b1;
          end else if (bus.job_fetch_complete) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          fetch_ack_q <= bus.job_fetch_request;
          if (leave) begin
            state_q   <= S_ACK;
            cpl_ack_q <= 1'b1;
          end
        end
        S_ACK: begin
          if (leave) begin
            state_q   <= S_IDLE;
            cpl_ack_q <= 1'b0;
            done_q    <= 1'b1;
            jobs_q    <= jobs_q + 1'b1;
          end
        end
        S_ERR: begin
          if (bus.err_clear) begin
            state_q <= S_IDLE;
            terr_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (leave) wd_q <= '0;
      if (timeout) begin
        state_q     <= S_ERR;
        err_state_q <= state_q;
        terr_q      <= 1'b1;
        job_start_q <= 1'b0;
        fetch_ack_q <= 1'b0;
        cpl_ack_q   <= 1'b0;
        wd_q        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_job_sequencer.sv
// Testbench for cnn_layer_accel_job_sequencer.
// Table jobs, timeout/reset sequences and random jobs vs a job model.
module tb_cnn_layer_accel_job_sequencer;

  localparam int TO = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_layer_accel_job_sequencer_if #(.C_CNT_WIDTH(CW)) bus ();

  cnn_layer_accel_job_sequencer #(
    .C_TIMEOUT_CYCLES(TO),
    .C_CNT_WIDTH(CW)
  ) dut (
    .clk_if(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]   ncfg;
    logic [1:0]   sel;
    logic [127:0] params;
    int           stall_w;
    int           stall_c;
    int           acc;
    logic [3:0]   fpat;
    logic [1:0]   rpat;
    bit           direct;
    bit           both;
    int           hold;
    logic [CW-1:0] expj;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int njobs = 0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic idle_inputs();
    bus.desc_valid         = 1'b0;
    bus.desc_params        = '0;
    bus.desc_num_cfg       = 4'd0;
    bus.desc_cfg_sel       = 2'd0;
    bus.cfg_word_valid     = 1'b0;
    bus.cfg_word_data      = '0;
    bus.config_accept      = 4'd0;
    bus.job_accept         = 1'b0;
    bus.job_fetch_request  = 1'b0;
    bus.job_fetch_complete = 1'b0;
    bus.job_complete       = 1'b0;
    bus.err_clear          = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.desc_ready && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("desc_ready_wait", bus.desc_ready, 1);
  endtask

  task automatic send_desc(input logic [127:0] p,
                           input logic [3:0] nc,
                           input logic [1:0] sl);
    wait_ready();
    bus.desc_valid   = 1'b1;
    bus.desc_params  = p;
    bus.desc_num_cfg = nc;
    bus.desc_cfg_sel = sl;
    @(negedge clk);
    bus.desc_valid = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    chk("ready_after_accept", bus.desc_ready, 0);
    chk("job_parameters", bus.job_parameters, p);
  endtask

  task automatic run_job(input vec_t v, input logic [CW-1:0] expj);
    logic [127:0] w;
    logic [3:0]   acc;
    send_desc(v.params, v.ncfg, v.sel);
    if (v.ncfg != 0) begin
      chk("start_during_cfg", bus.job_start, 0);
      for (int i = 0; i < int'(v.ncfg); i++) begin
        int ns;
        ns = (i == v.stall_w) ? v.stall_c : 0;
        w = {$urandom, $urandom, $urandom, $urandom};
        for (int s = 0; s <= ns; s++) begin
          acc = 4'($urandom);
          acc[v.sel] = (s == ns);
          bus.cfg_word_valid = 1'b1;
          bus.cfg_word_data  = w;
          bus.config_accept  = acc;
          #1;
          chk("config_valid", bus.config_valid,
              128'(4'b0001 << v.sel));
          chk("config_data", bus.config_data, w);
          chk("cfg_word_ready", bus.cfg_word_ready, acc[v.sel]);
          @(negedge clk);
        end
      end
      bus.cfg_word_valid = 1'b0;
      bus.config_accept  = 4'hF;
      #1;
      chk("config_valid_after", bus.config_valid, 0);
      chk("cfg_ready_after", bus.cfg_word_ready, 0);
      bus.config_accept = 4'd0;
    end
    chk("job_start_entry", bus.job_start, 1);
    for (int d = 0; d < v.acc; d++) begin
      @(negedge clk);
      chk("job_start_held", bus.job_start, 1);
    end
    bus.job_accept = 1'b1;
    @(negedge clk);
    bus.job_accept = 1'b0;
    chk("job_start_drop", bus.job_start, 0);
    for (int i = 0; i < 4; i++) begin
      bus.job_fetch_request = v.fpat[i];
      @(negedge clk);
      chk("fetch_ack", bus.job_fetch_ack, v.fpat[i]);
    end
    bus.job_fetch_request = 1'b0;
    if (!v.direct) begin
      bus.job_fetch_complete = 1'b1;
      @(negedge clk);
      bus.job_fetch_complete = 1'b0;
      chk("fetch_ack_idle", bus.job_fetch_ack, 0);
      for (int i = 0; i < 2; i++) begin
        bus.job_fetch_request = v.rpat[i];
        @(negedge clk);
        chk("run_fetch_ack", bus.job_fetch_ack, v.rpat[i]);
        chk("run_no_cpl_ack", bus.job_complete_ack, 0);
      end
      bus.job_fetch_request = 1'b0;
    end
    bus.job_complete       = 1'b1;
    bus.job_fetch_complete = v.both;
    @(negedge clk);
    bus.job_fetch_complete = 1'b0;
    chk("cpl_ack_entry", bus.job_complete_ack, 1);
    for (int k = 1; k < v.hold; k++) begin
      chk("done_in_ack", bus.done_pulse, 0);
      @(negedge clk);
      chk("cpl_ack_hold", bus.job_complete_ack, 1);
    end
    bus.job_complete = 1'b0;
    @(negedge clk);
    chk("cpl_ack_drop", bus.job_complete_ack, 0);
    chk("done_pulse", bus.done_pulse, 1);
    chk("jobs_done", bus.jobs_done, expj);
    chk("busy_idle", bus.busy, 0);
    chk("no_timeout", bus.timeout_err, 0);
    @(negedge clk);
    chk("done_one_cycle", bus.done_pulse, 0);
    chk("ready_next", bus.desc_ready, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, bus.desc_ready, 0);
    chk({tag, "_start"}, bus.job_start, 0);
    chk({tag, "_fack"}, bus.job_fetch_ack, 0);
    chk({tag, "_cack"}, bus.job_complete_ack, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done_pulse, 0);
    chk({tag, "_jobs"}, bus.jobs_done, 0);
    chk({tag, "_terr"}, bus.timeout_err, 0);
    chk({tag, "_estate"}, bus.err_state, 0);
    chk({tag, "_params"}, bus.job_parameters, 0);
    chk({tag, "_cvalid"}, bus.config_valid, 0);
  endtask

  function automatic logic [CW-1:0] model_jobs(input int n);
    return CW'(n % (1 << CW));
  endfunction

  vec_t tbl[5];
  vec_t rv;

  initial begin
    tbl[0] = '{4'd0, 2'd0, 128'hA5, 0, 0, 3, 4'b0011, 2'b00,
               1'b0, 1'b0, 4, 4'd1};
    tbl[1] = '{4'd3, 2'd2, 128'h0123_4567_89ab_cdef_fedc_ba98,
               1, 2, 0, 4'b0101, 2'b10, 1'b0, 1'b0, 1, 4'd2};
    tbl[2] = '{4'd0, 2'd0, 128'hdead_beef, 0, 0, 1, 4'b0000,
               2'b00, 1'b1, 1'b0, 2, 4'd3};
    tbl[3] = '{4'd1, 2'd3, 128'h5a5a, 0, 0, 7, 4'b1111, 2'b00,
               1'b1, 1'b1, 8, 4'd4};
    tbl[4] = '{4'd2, 2'd1, 128'hcafe, 1, 6, 2, 4'b1001, 2'b11,
               1'b0, 1'b0, 3, 4'd5};

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst = 1'b0;
    chk("ready_at_release", bus.desc_ready, 0);
    @(negedge clk);
    chk("ready_after_rst", bus.desc_ready, 1);

    for (int t = 0; t < 5; t++) begin
      run_job(tbl[t], tbl[t].expj);
    end
    njobs = 5;

    // Watchdog: START never accepted.
    send_desc(128'h1234, 4'd0, 2'd0);
    for (int i = 0; i < TO; i++) begin
      chk("wd_start_held", bus.job_start, 1);
      chk("wd_no_err_yet", bus.timeout_err, 0);
      @(negedge clk);
    end
    chk("wd_terr", bus.timeout_err, 1);
    chk("wd_estate", bus.err_state, 2);
    chk("wd_start_low", bus.job_start, 0);
    chk("wd_busy", bus.busy, 1);
    chk("wd_ready", bus.desc_ready, 0);
    bus.desc_valid = 1'b1;
    @(negedge clk);
    bus.desc_valid = 1'b0;
    chk("err_sticky", bus.timeout_err, 1);
    chk("err_ready", bus.desc_ready, 0);
    bus.err_clear = 1'b1;
    @(negedge clk);
    bus.err_clear = 1'b0;
    chk("clr_terr", bus.timeout_err, 0);
    chk("clr_busy", bus.busy, 0);
    chk("clr_estate_hold", bus.err_state, 2);
    chk("clr_jobs", bus.jobs_done, model_jobs(njobs));
    @(negedge clk);
    chk("clr_ready", bus.desc_ready, 1);

    // Reset in RUN with a fetch request pending.
    send_desc(128'h77, 4'd0, 2'd0);
    bus.job_accept = 1'b1;
    @(negedge clk);
    bus.job_accept = 1'b0;
    bus.job_fetch_complete = 1'b1;
    @(negedge clk);
    bus.job_fetch_complete = 1'b0;
    bus.job_fetch_request = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    bus.job_fetch_request = 1'b0;
    njobs = 0;
    @(negedge clk);
    chk("midrst_ready", bus.desc_ready, 1);

    // Random jobs; count crosses the wrap point.
    for (int j = 0; j < 19; j++) begin
      rv.ncfg    = 4'($urandom_range(0, 3));
      rv.sel     = 2'($urandom_range(0, 3));
      rv.params  = {$urandom, $urandom, $urandom, $urandom};
      rv.stall_w = $urandom_range(0, 2);
      rv.stall_c = $urandom_range(0, 1);
      rv.acc     = $urandom_range(0, 6);
      rv.fpat    = 4'($urandom);
      rv.rpat    = 2'($urandom);
      rv.direct  = 1'($urandom);
      rv.both    = 1'($urandom);
      rv.hold    = $urandom_range(1, 4);
      njobs++;
      rv.expj    = model_jobs(njobs);
      run_job(rv, rv.expj);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
